// File: rtl/multiword_adder_ctrl_amisha_pkg.sv
// Shared types and constants for the multi-word adder controller.
// Used by the controller and its slice adder.
package multiword_adder_pkg_amisha;

   // Controller states: waiting, stepping through words, result strobe.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Default slice width and word count.
   localparam int DEF_N = 4;
   localparam int DEF_W = 4;

   // Ceiling log2, used to size the word index.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/multiword_adder_ctrl_amisha_slice.sv
// Combinational N-bit adder slice with carry in and carry out.
// The controller time-multiplexes one word pair per clock onto this slice.
module adder_slice_amisha #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);

   // Zero-extend to N+1 bits so bit N of the result is the carry out.
   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/multiword_adder_ctrl_amisha.sv
// Multi-cycle wide adder: adds two N*W-bit operands one N-bit word per
// clock, least-significant word first, through a single shared slice.
// Optional macro MULTIWORD_ADDER_SUB_EN adds a sub_amisha port that turns
// the operation into A-B (B inverted per word, initial carry 1).
module multiword_adder_ctrl_amisha
   import multiword_adder_pkg_amisha::*;
#(
   parameter int N = DEF_N,
   parameter int W = DEF_W
) (
   input  logic           clk_amisha,
   input  logic           reset_amisha,
   input  logic           start_amisha,
   input  logic [N*W-1:0] a_amisha,
   input  logic [N*W-1:0] b_amisha,
`ifdef MULTIWORD_ADDER_SUB_EN
   input  logic           sub_amisha,
`endif
   output logic           busy_amisha,
   output logic           done_amisha,
   output logic [N*W-1:0] sum_amisha,
   output logic           cout_amisha
);

   // A single word still needs a 1-bit index register.
   localparam int IDX_W = (clog2(W) > 0) ? clog2(W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

   state_t                state;
   logic [W-1:0][N-1:0]   a_q;
   logic [W-1:0][N-1:0]   b_q;
   logic [W-1:0][N-1:0]   sum_q;
   logic [IDX_W-1:0]      idx;
   logic                  carry;
   logic [N-1:0]          slice_a;
   logic [N-1:0]          slice_b;
   logic [N-1:0]          slice_s;
   logic                  slice_cout;
`ifdef MULTIWORD_ADDER_SUB_EN
   logic                  sub_q;
`endif

   // Select the current word pair for the shared slice.
   assign slice_a = a_q[idx];
`ifdef MULTIWORD_ADDER_SUB_EN
   assign slice_b = sub_q ? ~b_q[idx] : b_q[idx];
`else
   assign slice_b = b_q[idx];
`endif

   adder_slice_amisha #(
      .N (N)
   ) u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry),
      .s    (slice_s),
      .cout (slice_cout)
   );

   assign sum_amisha = sum_q;

   // Controller FSM: accept in IDLE, one word per edge in ADD, strobe in DONE.
   always_ff @(posedge clk_amisha) begin
      // NOTE: non-blocking assignments throughout, so every register in this
      // block sees the pre-edge values of the others (idx, carry, state).
      if (reset_amisha) begin
         state       <= IDLE;
         idx         <= '0;
         carry       <= 1'b0;
         busy_amisha <= 1'b0;
         done_amisha <= 1'b0;
         cout_amisha <= 1'b0;
         sum_q       <= '0;
`ifdef MULTIWORD_ADDER_SUB_EN
         sub_q       <= 1'b0;
`endif
         // NOTE: a_q/b_q are deliberately not reset; they are only read in
         // ADD, which is always preceded by an accept that reloads them.
      end else begin
         done_amisha <= 1'b0;
         case (state)
            IDLE: begin
               if (start_amisha) begin
                  a_q         <= a_amisha;
                  b_q         <= b_amisha;
                  idx         <= '0;
`ifdef MULTIWORD_ADDER_SUB_EN
                  sub_q       <= sub_amisha;
                  carry       <= sub_amisha;
`else
                  carry       <= 1'b0;
`endif
                  busy_amisha <= 1'b1;
                  state       <= ADD;
               end
            end
            ADD: begin
               sum_q[idx] <= slice_s;
               carry      <= slice_cout;
               idx        <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  cout_amisha <= slice_cout;
                  done_amisha <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               busy_amisha <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               busy_amisha <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiword_adder_ctrl_amisha.sv
// Self-checking bench for multiword_adder_ctrl_amisha (N=4, W=4).
// Table of directed add (and, with MULTIWORD_ADDER_SUB_EN, subtract)
// vectors run back-to-back, plus hand-written start-while-busy and
// reset-mid-operation sequences. Outputs are sampled on the falling edge.
module tb_multiword_adder_ctrl_amisha;

   localparam int N = 4;
   localparam int W = 4;

   typedef struct {
      string       name;
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic [15:0] exp_sum;
      logic        exp_cout;
   } vec_t;

   logic        clk_amisha = 1'b0;
   logic        reset_amisha;
   logic        start_amisha;
   logic [15:0] a_amisha;
   logic [15:0] b_amisha;
`ifdef MULTIWORD_ADDER_SUB_EN
   logic        sub_amisha;
`endif
   logic        busy_amisha;
   logic        done_amisha;
   logic [15:0] sum_amisha;
   logic        cout_amisha;

   int n_checks = 0;
   int n_pass   = 0;

   vec_t vecs[$];

   multiword_adder_ctrl_amisha #(
      .N (N),
      .W (W)
   ) dut (
      .clk_amisha   (clk_amisha),
      .reset_amisha (reset_amisha),
      .start_amisha (start_amisha),
      .a_amisha     (a_amisha),
      .b_amisha     (b_amisha),
`ifdef MULTIWORD_ADDER_SUB_EN
      .sub_amisha   (sub_amisha),
`endif
      .busy_amisha  (busy_amisha),
      .done_amisha  (done_amisha),
      .sum_amisha   (sum_amisha),
      .cout_amisha  (cout_amisha)
   );

   always #5 clk_amisha = ~clk_amisha;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // One operation from an IDLE falling edge. Returns the edge offset (from
   // the accept edge) where done was first seen, the number of done pulses,
   // the result at done, and state one edge after DONE (the first IDLE cycle).
   task automatic run_op(input vec_t v, output int done_edge, output int n_done,
                         output logic [15:0] sum_d, output logic cout_d,
                         output logic busy_acc, output logic [15:0] sum_end,
                         output logic cout_end, output logic busy_end);
      done_edge = -1;
      n_done    = 0;
      sum_d     = '0;
      cout_d    = 1'b0;
      start_amisha = 1'b1;
      a_amisha     = v.a;
      b_amisha     = v.b;
`ifdef MULTIWORD_ADDER_SUB_EN
      sub_amisha   = v.sub;
`endif
      @(posedge clk_amisha);
      @(negedge clk_amisha);
      busy_acc     = busy_amisha;
      // Operands are free to change once accepted.
      start_amisha = 1'b0;
      a_amisha     = ~v.a;
      b_amisha     = v.a ^ v.b ^ 16'h5A5A;
`ifdef MULTIWORD_ADDER_SUB_EN
      sub_amisha   = ~v.sub;
`endif
      for (int e = 1; e <= W + 1; e++) begin
         @(posedge clk_amisha);
         @(negedge clk_amisha);
         if (done_amisha) begin
            n_done++;
            if (done_edge < 0) begin
               done_edge = e;
               sum_d     = sum_amisha;
               cout_d    = cout_amisha;
            end
         end
      end
      sum_end  = sum_amisha;
      cout_end = cout_amisha;
      busy_end = busy_amisha;
   endtask

   initial begin
      int          done_edge;
      int          n_done;
      logic [15:0] sum_d;
      logic        cout_d;
      logic        busy_acc;
      logic [15:0] sum_end;
      logic        cout_end;
      logic        busy_end;
      logic        done_h [0:15];
      logic        busy_h [0:15];
      logic [15:0] sum_h  [0:15];
      int          cnt;
      vec_t        v;

      vecs.push_back('{"add_basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0});
      vecs.push_back('{"add_ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1});
      vecs.push_back('{"add_topcar",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1});
      vecs.push_back('{"add_zero",    16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0});
      vecs.push_back('{"add_mid",     16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0});
      vecs.push_back('{"add_alt",     16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1});
      vecs.push_back('{"add_mixed",   16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0});
`ifdef MULTIWORD_ADDER_SUB_EN
      vecs.push_back('{"sub_borrow",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0});
      vecs.push_back('{"sub_noborr",  16'h0100, 16'h0001, 1'b1, 16'h00FF, 1'b1});
      vecs.push_back('{"sub_equal",   16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1});
`endif

      // Reset with start also high: reset must win.
      reset_amisha = 1'b1;
      start_amisha = 1'b1;
      a_amisha     = 16'h0001;
      b_amisha     = 16'h0001;
`ifdef MULTIWORD_ADDER_SUB_EN
      sub_amisha   = 1'b0;
`endif
      repeat (2) @(posedge clk_amisha);
      @(negedge clk_amisha);
      reset_amisha = 1'b0;
      start_amisha = 1'b0;
      check("rst_busy", 32'(busy_amisha), 32'd0);
      check("rst_done", 32'(done_amisha), 32'd0);
      check("rst_sum",  32'(sum_amisha),  32'd0);
      check("rst_cout", 32'(cout_amisha), 32'd0);

      // Table vectors, each started on the first IDLE edge after the
      // previous operation (back-to-back).
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         run_op(v, done_edge, n_done, sum_d, cout_d, busy_acc, sum_end, cout_end, busy_end);
         check($sformatf("%s_busy_acc", v.name), 32'(busy_acc), 32'd1);
         // done first seen after edge k+W: W+1 cycles counting the accept cycle.
         check($sformatf("%s_done_edge", v.name), 32'(done_edge), 32'(W));
         check($sformatf("%s_n_done", v.name),   32'(n_done),    32'd1);
         check($sformatf("%s_sum", v.name),      32'(sum_d),     32'(v.exp_sum));
         check($sformatf("%s_cout", v.name),     32'(cout_d),    32'(v.exp_cout));
         check($sformatf("%s_sum_hold", v.name), 32'(sum_end),   32'(v.exp_sum));
         check($sformatf("%s_cout_hold", v.name), 32'(cout_end), 32'(v.exp_cout));
         check($sformatf("%s_busy_end", v.name), 32'(busy_end),  32'd0);
      end

      // Start held for 8 edges (k..k+7); A changes after accept.
      start_amisha = 1'b1;
      a_amisha     = 16'h0001;
      b_amisha     = 16'h0001;
`ifdef MULTIWORD_ADDER_SUB_EN
      sub_amisha   = 1'b0;
`endif
      @(posedge clk_amisha);
      @(negedge clk_amisha);
      for (int e = 1; e <= 12; e++) begin
         a_amisha     = 16'h00FF;
         start_amisha = (e <= 7);
         @(posedge clk_amisha);
         @(negedge clk_amisha);
         done_h[e] = done_amisha;
         busy_h[e] = busy_amisha;
         sum_h[e]  = sum_amisha;
      end
      cnt = 0;
      for (int e = 1; e <= W + 1; e++) if (done_h[e]) cnt++;
      check("hold_one_done",   32'(cnt),           32'd1);
      check("hold_done_edge",  32'(done_h[W]),     32'd1);
      check("hold_sum",        32'(sum_h[W]),      32'h0002);
      check("hold_idle",       32'(busy_h[W+1]),   32'd0);
      // Held start is taken on the first IDLE edge (k+W+2).
      check("hold_reaccept",   32'(busy_h[W+2]),   32'd1);
      check("hold_done2",      32'(done_h[2*W+2]), 32'd1);
      check("hold_sum2",       32'(sum_h[2*W+2]),  32'h0100);

      // Leave a nonzero sum and cout=1 before the reset test.
      v = '{"pre_rst", 16'hFFFF, 16'h0002, 1'b0, 16'h0001, 1'b1};
      run_op(v, done_edge, n_done, sum_d, cout_d, busy_acc, sum_end, cout_end, busy_end);
      check("pre_rst_sum",  32'(sum_end),  32'h0001);
      check("pre_rst_cout", 32'(cout_end), 32'd1);

      // Reset on the 2nd ADD edge (k+2).
      start_amisha = 1'b1;
      a_amisha     = 16'h1111;
      b_amisha     = 16'h2222;
      @(posedge clk_amisha);
      @(negedge clk_amisha);
      start_amisha = 1'b0;
      @(posedge clk_amisha);
      @(negedge clk_amisha);
      reset_amisha = 1'b1;
      @(posedge clk_amisha);
      @(negedge clk_amisha);
      reset_amisha = 1'b0;
      check("midrst_busy", 32'(busy_amisha), 32'd0);
      check("midrst_done", 32'(done_amisha), 32'd0);
      check("midrst_sum",  32'(sum_amisha),  32'd0);
      check("midrst_cout", 32'(cout_amisha), 32'd0);
      cnt = 0;
      for (int e = 0; e < 6; e++) begin
         @(posedge clk_amisha);
         @(negedge clk_amisha);
         if (done_amisha || busy_amisha) cnt++;
      end
      check("midrst_quiet", 32'(cnt), 32'd0);

      v = '{"post_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0};
      run_op(v, done_edge, n_done, sum_d, cout_d, busy_acc, sum_end, cout_end, busy_end);
      check("post_rst_edge", 32'(done_edge), 32'(W));
      check("post_rst_sum",  32'(sum_d),     32'h0007);
      check("post_rst_cout", 32'(cout_d),    32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
